mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter on the ktc16 store path, downstream of the CPU alongside `ram`. It decodes CPU stores (`memwrite`, `addr`, `wd`) into a small byte FIFO, serialises bytes as 8N1 on `txd`, and returns a status word on the CPU read bus when its address window is selected. Programs use it to emit characters and pass/fail codes instead of relying on magic RAM addresses.

## Interface
- `BASE_ADDR`, 16'hFF00: window base; must be a multiple of 8. DATA = BASE_ADDR, STATUS = BASE_ADDR+4.
- `CLKS_PER_BIT`, 16: clk cycles per UART bit, ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of 2, 2..16.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `memwrite` input 1: CPU store strobe, same as RAM write enable.
- `addr` input 16: CPU address.
- `wd` input 16: CPU store data.
- `sel` output 1: combinational; 1 when `addr` is within BASE_ADDR..BASE_ADDR+7; top-level muxes `rd_dev` over RAM data.
- `rd_dev` output 32: combinational; STATUS word when `addr` == STATUS, else 0.
- `txd` output 1: serial line, idle high.

## Operation
- Store to DATA: pushes `wd[7:0]`; `wd[15:8]` ignored. Dropped if FIFO full, and sets sticky `overflow`.
- Store to STATUS, any data: clears `overflow`.
- Stores to BASE+1..3, BASE+5..7: no effect. Stores outside the window: ignored.
- STATUS word: [0] busy = FSM not IDLE or FIFO not empty; [1] full; [2] empty; [3] overflow; [8:4] count, 0..FIFO_DEPTH; [31:9] = 0.
- FIFO: circular, rd/wr pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, separate count register. Full = count==FIFO_DEPTH; empty = count==0.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into the shift register, go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: 0..CLKS_PER_BIT-1; reloads to 0 on every state change.
- Simultaneous push and pop:
  - If not full, count is unchanged.
  - If full, the push is accepted because the pop frees a slot; `overflow` is not set.
- Reset (any time, including mid-frame):
  - FSM→IDLE; FIFO emptied, pointers and count = 0; `overflow`=0; `txd`=1.
  - A partially sent frame is abandoned. The line returns high immediately (asynchronously).

## Timing
- Reset values: `txd`=1; STATUS = 0x4 (empty only). `sel` and `rd_dev` follow `addr` combinationally.
- Store at rising edge N: count increments at N.
  - If FSM was IDLE and FIFO empty: pop at edge N+1; `txd` falls at N+1.
  - Start bit spans edges N+1..N+1+CLKS_PER_BIT.
  - Full frame = 10·CLKS_PER_BIT cycles.
  - Next queued byte's start bit begins on the edge after the stop bit ends (1 idle-evaluation cycle, `txd`=1).
- Back-to-back frames: exactly 10·CLKS_PER_BIT + 1 cycles start-to-start.
- Status reads reflect register state after the most recent edge; there is no read side effect.
- `busy` falls on the edge that leaves STOP with FIFO empty.

## Test plan
- Reset: pulse `reset` low at t=10ns, release at t=20ns → `txd`=1, STATUS=0x00000004, `sel`=0 for addr=80.
- Single byte: store 0x0155 to 0xFF00 with CLKS_PER_BIT=16 → `txd` low at next edge for 16 cycles, then bits 1,0,1,0,1,0,1,0, then high; busy clears after 161 cycles; STATUS returns 0x4.
- Overflow: 10 stores to 0xFF00 within 10 cycles, DEPTH=8 → first byte popped at cycle 2, so 9 bytes accepted and 1 dropped. STATUS shows full=1, overflow=1, count=8. Store to 0xFF04 → overflow=0. Exactly 9 frames are emitted, in order.
- Full push/pop same edge: fill FIFO while FSM is in STOP; push on the IDLE pop edge → push accepted, count stays 8, overflow=0.
- Reset mid-frame: assert `reset` during DATA bit 3 → `txd`=1 immediately; after release, STATUS=0x4 and no further frames.
- Decode: store 7 to addr 84 and to 0xFF02 → no FIFO change, `sel`=0 for 84 and 1 for 0xFF02, `rd_dev`=0 at 0xFF02.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU store path.
// DATA (BASE_ADDR) queues a byte. STATUS (BASE_ADDR+4) reports the FIFO and
// transmitter state, and a store to it clears the sticky overflow flag.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wd,
    output logic        sel,
    output logic [31:0] rd_dev,
    output logic        txd
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = 5;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST_C = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    logic [7:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    tx_state_t         state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              txd_r;

    logic              sel_s;
    logic              data_wr_s;
    logic              status_wr_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              busy_s;
    logic [31:0]       status_s;
    logic              wd_hi_unused_s;

    // The upper store byte carries no meaning for this device.
    assign wd_hi_unused_s = ^wd[15:8];

    // Address decode of the 8-byte window and the two active store targets.
    always_comb begin
        sel_s       = (addr[15:3] == BASE_ADDR[15:3]);
        data_wr_s   = memwrite && sel_s && (addr[2:0] == 3'd0);
        status_wr_s = memwrite && sel_s && (addr[2:0] == 3'd4);
    end

    // FIFO flags, push/pop handshake and the STATUS word.
    always_comb begin
        full_s   = (count_r == DEPTH_C);
        empty_s  = (count_r == {CNT_W{1'b0}});
        pop_s    = (state_r == ST_IDLE) && !empty_s;
        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        push_s   = data_wr_s && (!full_s || pop_s);
        busy_s   = (state_r != ST_IDLE) || !empty_s;
        status_s = {23'd0, count_r, overflow_r, empty_s, full_s, busy_s};
    end

    // Read-bus mux: STATUS only at its own address, zero elsewhere.
    always_comb begin
        sel = sel_s;
        if (sel_s && (addr[2:0] == 3'd4)) begin
            rd_dev = status_s;
        end else begin
            rd_dev = 32'd0;
        end
    end

    // FIFO storage array written on accepted pushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wd[7:0];
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (data_wr_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (status_wr_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit; txd is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= {BAUD_W{1'b0}};
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= fifo_mem_r[rd_ptr_r];
                        state_r <= ST_START;
                        txd_r   <= 1'b0;
                    end else begin
                        txd_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_r == BAUD_LAST_C) begin
                        baud_r    <= {BAUD_W{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                        txd_r     <= shift_r[0];
                    end else begin
                        baud_r    <= baud_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_r == BAUD_LAST_C) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_r == BAUD_LAST_C) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        state_r <= ST_IDLE;
                        txd_r   <= 1'b1;
                    end else begin
                        baud_r  <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    baud_r    <= {BAUD_W{1'b0}};
                    bit_idx_r <= 3'd0;
                    txd_r     <= 1'b1;
                end
            endcase
        end
    end

    assign txd = txd_r;

endmodule
